// File: rtl/calc_sequencer_if.sv
// Switch/button inputs and display-side outputs of the calculator sequencer.
`timescale 1ns/1ps
interface calc_sequencer_if #(parameter int WIDTH = 9);
    logic [WIDTH-1:0] num_in;
    logic [1:0]       op_in;
    logic             enter;
    logic             clear;
    logic [WIDTH-1:0] mem_a;
    logic [WIDTH-1:0] mem_b;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic [2:0]       state;
    logic             busy;
    logic             done;

    modport master (
        output num_in, op_in, enter, clear,
        input  mem_a, mem_b, result, ovf, state, busy, done
    );

    modport slave (
        input  num_in, op_in, enter, clear,
        output mem_a, mem_b, result, ovf, state, busy, done
    );
endinterface

// File: rtl/calc_sequencer.sv
// Operand-entry sequencer and ALU for the calculator, with a shift-add multiplier.
// state  | meaning
// S_A    | wait for enter, capture first operand
// S_OP   | wait for enter, capture operator
// S_B    | wait for enter, capture second operand
// S_CALC | operation running (1 cycle, or WIDTH+2 cycles for mul)
// S_SHOW | result displayed; enter chains result into first operand
`timescale 1ns/1ps
module calc_sequencer #(
    parameter int WIDTH       = 9,
    parameter int SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst,
    calc_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [2*WIDTH-1:0] LIM_POS = (2*WIDTH)'((1 << (WIDTH-1)) - 1);
    localparam logic [2*WIDTH-1:0] LIM_NEG = (2*WIDTH)'(1 << (WIDTH-1));

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_CALC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       mem_a_q, mem_a_d;
    logic [WIDTH-1:0]       mem_b_q, mem_b_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;
    logic [1:0]             op_q, op_d;
    logic                   mul_act_q, mul_act_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [SYNC_STAGES-1:0] enter_sync_q, clear_sync_q;
    logic                   enter_prev_q;

    logic                   enter_s, enter_p, clear_s;
    logic [WIDTH-1:0]       sum, diff;
    logic                   prod_neg;
    logic [2*WIDTH-1:0]     prod_signed;

    // Magnitude fits WIDTH bits unsigned, including the most negative value.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign enter_s     = enter_sync_q[SYNC_STAGES-1];
    assign clear_s     = clear_sync_q[SYNC_STAGES-1];
    assign enter_p     = enter_s & ~enter_prev_q;
    assign sum         = mem_a_q + mem_b_q;
    assign diff        = mem_a_q - mem_b_q;
    assign prod_neg    = mem_a_q[WIDTH-1] ^ mem_b_q[WIDTH-1];
    assign prod_signed = prod_neg ? -acc_q : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_A;
            mem_a_q      <= '0;
            mem_b_q      <= '0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            op_q         <= '0;
            mul_act_q    <= 1'b0;
            cnt_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            enter_sync_q <= '0;
            clear_sync_q <= '0;
            enter_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_a_q      <= mem_a_d;
            mem_b_q      <= mem_b_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
            op_q         <= op_d;
            mul_act_q    <= mul_act_d;
            cnt_q        <= cnt_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            enter_sync_q <= SYNC_STAGES'({enter_sync_q, bus.enter});
            clear_sync_q <= SYNC_STAGES'({clear_sync_q, bus.clear});
            enter_prev_q <= enter_s;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_a_d   = mem_a_q;
        mem_b_d   = mem_b_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        op_d      = op_q;
        mul_act_d = mul_act_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;

        if (clear_s) begin
            state_d   = S_A;
            mem_a_d   = '0;
            mem_b_d   = '0;
            result_d  = '0;
            ovf_d     = 1'b0;
            op_d      = '0;
            mul_act_d = 1'b0;
            cnt_d     = '0;
            mcand_d   = '0;
            mplier_d  = '0;
            acc_d     = '0;
        end else begin
            case (state_q)
                S_A: if (enter_p) begin
                    mem_a_d = bus.num_in;
                    state_d = S_OP;
                end
                S_OP: if (enter_p) begin
                    op_d    = bus.op_in;
                    state_d = S_B;
                end
                S_B: if (enter_p) begin
                    mem_b_d = bus.num_in;
                    state_d = S_CALC;
                end
                S_CALC: begin
                    if (op_q == 2'b10) begin
                        // Load cycle, then WIDTH iterations, then sign/overflow finalize.
                        if (!mul_act_q) begin
                            mcand_d   = {{WIDTH{1'b0}}, mag(mem_a_q)};
                            mplier_d  = mag(mem_b_q);
                            acc_d     = '0;
                            cnt_d     = CW'(WIDTH);
                            mul_act_d = 1'b1;
                        end else if (cnt_q != '0) begin
                            if (mplier_q[0]) acc_d = acc_q + mcand_q;
                            mcand_d  = mcand_q << 1;
                            mplier_d = mplier_q >> 1;
                            cnt_d    = cnt_q - CW'(1);
                        end else begin
                            result_d  = prod_signed[WIDTH-1:0];
                            ovf_d     = prod_neg ? (acc_q > LIM_NEG) : (acc_q > LIM_POS);
                            mul_act_d = 1'b0;
                            done_d    = 1'b1;
                            state_d   = S_SHOW;
                        end
                    end else begin
                        case (op_q)
                            2'b00: begin
                                result_d = sum;
                                ovf_d    = (mem_a_q[WIDTH-1] == mem_b_q[WIDTH-1]) &&
                                           (sum[WIDTH-1] != mem_a_q[WIDTH-1]);
                            end
                            2'b01: begin
                                result_d = diff;
                                ovf_d    = (mem_a_q[WIDTH-1] != mem_b_q[WIDTH-1]) &&
                                           (diff[WIDTH-1] != mem_a_q[WIDTH-1]);
                            end
                            default: begin
                                result_d = mem_b_q;
                                ovf_d    = 1'b0;
                            end
                        endcase
                        done_d  = 1'b1;
                        state_d = S_SHOW;
                    end
                end
                S_SHOW: if (enter_p) begin
                    mem_a_d = result_q;
                    mem_b_d = '0;
                    state_d = S_OP;
                end
                default: state_d = S_A;
            endcase
        end
    end

    assign bus.mem_a  = mem_a_q;
    assign bus.mem_b  = mem_b_q;
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;
    assign bus.state  = state_q;
    assign bus.busy   = (state_q == S_CALC);
    assign bus.done   = done_q;
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Top-level operation controller for the simple calculator.
- Sequences operand entry (first number, operator, second number) from the enter button and stores both operands.
- Runs the selected arithmetic operation and holds the result for display, including a sequential shift-add multiplier.
- Sits between the switch/button inputs and the display driver; replaces edge-triggered operand capture with a single synchronous clock domain.

Parameters:
- WIDTH, 9, operand/result width, two's complement.
- SYNC_STAGES, 2, synchronizer flops on the enter and clear button inputs.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- num_in  input  WIDTH  number from switches, two's complement
- op_in  input  2  operator select: 00 add, 01 sub, 10 mul, 11 load (result = B)
- enter  input  1  enter button, asynchronous level
- clear  input  1  clear button, asynchronous level
- mem_a  output  WIDTH  stored first operand
- mem_b  output  WIDTH  stored second operand
- result  output  WIDTH  last computed result
- ovf  output  1  overflow of last result
- state  output  3  current state code, for display and debug
- busy  output  1  high while in S_CALC
- done  output  1  one-cycle pulse when the result becomes valid

Behaviour:
- Reset: all outputs and internal registers are 0; state is S_A; synchronizer flops are cleared.
- Input conditioning:
  - enter and clear each pass through SYNC_STAGES flops.
  - enter_p is a one-cycle rising-edge pulse of the synchronized enter.
  - clear_s is the synchronized level of clear.
  - Action latency from an enter edge to the register update is SYNC_STAGES+1 clocks.
- State codes: S_A=0, S_OP=1, S_B=2, S_CALC=3, S_SHOW=4.
- Transitions, each on enter_p unless stated:
  - S_A: mem_a<=num_in; go to S_OP.
  - S_OP: latch op_in internally; go to S_B.
  - S_B: mem_b<=num_in; go to S_CALC.
  - S_CALC: enter_p is ignored. When the operation completes, register result and ovf, go to S_SHOW, and pulse done for 1 cycle.
  - S_SHOW: chain operation. mem_a<=result, mem_b<=0, go to S_OP. The result stays displayed until it is overwritten.
- Priority: clear_s high in any state forces S_A and zeroes mem_a, mem_b, result, ovf and the multiplier state. A multiply in progress is aborted with no done pulse. clear takes priority over enter_p in the same cycle. While clear_s stays high, the block remains in S_A.
- Add/sub/load: completes in 1 cycle in S_CALC; S_SHOW follows on the next clock.
  - Result wraps modulo 2^WIDTH.
  - ovf for add/sub: both operands have the same sign (for sub, compare A with -B) and the result sign differs.
  - ovf for load is 0.
- Mul: iterative shift-add on magnitudes.
  - Cycle 0 of S_CALC: load |A| and |B| (WIDTH bits each; |-256|=256 is representable) and clear the 2*WIDTH-bit accumulator.
  - Then WIDTH iteration cycles, one multiplier bit per cycle, LSB first.
  - Then 1 finalize cycle: apply sign (A sign XOR B sign), truncate to the low WIDTH bits, set ovf if the true signed product lies outside -2^(WIDTH-1)..2^(WIDTH-1)-1.
  - Total S_CALC dwell is WIDTH+2 cycles (11 at default).
  - A zero operand gives result 0 and ovf 0, with the same latency.
- busy = (state==S_CALC).
- result, ovf and mem_* change only as stated above; they are held in every other cycle.
- An enter pulse while the button is held produces a single action; release and re-press are required for the next action.

Test Plan:
- Reset, then enter 25, op 00, enter 17 → after the B latch, S_CALC lasts 1 cycle; result=9'd42, ovf=0, done pulses once, state=4.
- Add 100+200 → result=9'h12C (-212), ovf=1. Sub -256-1 → result=9'h0FF, ovf=1.
- Mul -3×7 → busy high for exactly 11 cycles, result=9'h1EB (-21), ovf=0. Mul 20×20 → result=9'h190, ovf=1. Mul 0×-5 → result=0, ovf=0.
- Chain: after 42 is shown, press enter, select op 01, enter B=2 → mem_a=42, result=40. Pressing enter during busy has no effect.
- Assert clear at the 5th cycle of a multiply → next state S_A, all outputs 0, no done pulse. Hold enter high for 20 cycles in S_A → exactly one transition to S_OP.
- Assert rst mid-sequence in S_B with enter pulsing in the same cycle → all outputs 0 and state=0 on the next clock.
